// File: rtl/shift_cmd_sequencer_if.sv
// Stream interface of shift_cmd_sequencer: command input port and result output port.
// SHIFT_SEQ_LOSS_EN adds res_loss, which travels with res_data.
interface shift_cmd_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 3
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [DATA_WIDTH-1:0]  cmd_data;
  logic                   cmd_dir;
  logic [SHAMT_WIDTH-1:0] cmd_shamt;
  logic                   res_valid;
  logic                   res_ready;
  logic [DATA_WIDTH-1:0]  res_data;
`ifdef SHIFT_SEQ_LOSS_EN
  logic                   res_loss;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_shamt, res_ready,
    input  cmd_ready, res_valid, res_data, res_loss
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_shamt, res_ready,
    output cmd_ready, res_valid, res_data, res_loss
  );
`else
  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_shamt, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_shamt, res_ready,
    output cmd_ready, res_valid, res_data
  );
`endif
endinterface

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: buffers shift commands in a small FIFO, drives a combinational
// barrel shifter from registers, captures its output one cycle later and holds the
// result on a valid/ready port until accepted.
// Optional feature macro: SHIFT_SEQ_LOSS_EN adds res_loss (a '1' bit was shifted out).
module shift_cmd_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  shift_cmd_sequencer_if.slave         bus,
  output logic [DATA_WIDTH-1:0]        sh_data_in,
  output logic                         sh_left_right_sel,
  output logic [SHAMT_WIDTH-1:0]       sh_bit_shift,
  input  logic [DATA_WIDTH-1:0]        sh_data_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]  data_mem  [FIFO_DEPTH];
  logic                   dir_mem   [FIFO_DEPTH];
  logic [SHAMT_WIDTH-1:0] shamt_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

`ifdef SHIFT_SEQ_LOSS_EN
  // Bits that do not survive the shift are those outside the "keep" mask.
  function automatic logic loss_calc(input logic [DATA_WIDTH-1:0]  d,
                                     input logic                   dir,
                                     input logic [SHAMT_WIDTH-1:0] amt);
    logic [DATA_WIDTH-1:0] keep;
    keep = dir ? ({DATA_WIDTH{1'b1}} << amt) : ({DATA_WIDTH{1'b1}} >> amt);
    return (d & ~keep) != '0;
  endfunction

  logic loss_p1;
`endif

  assign full          = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty         = (fifo_count == '0);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;

  // Next-state and pop decision; a pop only happens when the result slot is free.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.res_valid && bus.res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= bus.cmd_data;
      dir_mem[wr_ptr]   <= bus.cmd_dir;
      shamt_mem[wr_ptr] <= bus.cmd_shamt;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Shifter drive registers: loaded from the FIFO head on pop, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_data_in        <= '0;
      sh_left_right_sel <= 1'b0;
      sh_bit_shift      <= '0;
    end else if (pop) begin
      sh_data_in        <= data_mem[rd_ptr];
      sh_left_right_sel <= dir_mem[rd_ptr];
      sh_bit_shift      <= shamt_mem[rd_ptr];
    end
  end

  // Result capture after the shifter has settled for one cycle; held until handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else if (state == DRIVE) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= sh_data_out;
    end else if (state == HOLD && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

`ifdef SHIFT_SEQ_LOSS_EN
  // Loss flag: computed from the popped command, then moved to the output with res_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_p1      <= 1'b0;
      bus.res_loss <= 1'b0;
    end else begin
      if (pop) begin
        loss_p1 <= loss_calc(data_mem[rd_ptr], dir_mem[rd_ptr], shamt_mem[rd_ptr]);
      end
      if (state == DRIVE) begin
        bus.res_loss <= loss_p1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Testbench for shift_cmd_sequencer: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a queue-based reference model.
// Honours SHIFT_SEQ_LOSS_EN when defined for the build.
module tb_shift_cmd_sequencer;

  localparam int DW    = 8;
  localparam int SW    = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          dir;
    logic [SW-1:0] s;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sh_data_in;
  logic          sh_left_right_sel;
  logic [SW-1:0] sh_bit_shift;
  logic [DW-1:0] sh_data_out;
  logic [2:0]    fifo_count;

  int checks = 0;
  int errors = 0;

  shift_cmd_sequencer_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus ();

  shift_cmd_sequencer #(
    .DATA_WIDTH (DW),
    .SHAMT_WIDTH(SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .sh_data_in       (sh_data_in),
    .sh_left_right_sel(sh_left_right_sel),
    .sh_bit_shift     (sh_bit_shift),
    .sh_data_out      (sh_data_out),
    .fifo_count       (fifo_count)
  );

  always #5 clk = ~clk;

  // Combinational barrel shifter seen by the sequencer.
  assign sh_data_out = sh_left_right_sel ? (sh_data_in >> sh_bit_shift)
                                         : (sh_data_in << sh_bit_shift);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_shift(input cmd_t c);
    return c.dir ? (c.d >> c.s) : (c.d << c.s);
  endfunction

  // A set bit is lost if it lands beyond either end of the word.
  function automatic bit ref_loss(input cmd_t c);
    bit lost;
    lost = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (c.d[i]) begin
        if (!c.dir && (i + int'(c.s) >= DW)) lost = 1'b1;
        if (c.dir && (i < int'(c.s)))        lost = 1'b1;
      end
    end
    return lost;
  endfunction

  // Reference model: a queue of waiting commands, one command being shifted,
  // and one result slot waiting for the consumer.
  cmd_t          mq[$];
  cmd_t          cur;
  cmd_t          m_sh;
  bit            busy;
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_loss;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    bit   hs, free, acc;
    cmd_t newc;
    if (rst_n === 1'b0) begin
      mq.delete();
      busy    = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_loss  = 1'b0;
      m_sh    = '0;
      chk_en  = 1'b1;
    end else begin
      hs     = m_valid && (bus.res_ready === 1'b1);
      free   = !busy && (!m_valid || hs);
      acc    = (bus.cmd_valid === 1'b1) && (mq.size() < DEPTH);
      newc.d   = bus.cmd_data;
      newc.dir = bus.cmd_dir;
      newc.s   = bus.cmd_shamt;
      if (hs) m_valid = 1'b0;
      if (busy) begin
        m_valid = 1'b1;
        m_data  = ref_shift(cur);
        m_loss  = ref_loss(cur);
        busy    = 1'b0;
      end
      if (free && mq.size() > 0) begin
        cur  = mq.pop_front();
        m_sh = cur;
        busy = 1'b1;
      end
      if (acc) mq.push_back(newc);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready",  bus.cmd_ready, (mq.size() < DEPTH));
      chk("fifo_count", fifo_count, mq.size());
      chk("res_valid",  bus.res_valid, m_valid);
      chk("res_data",   bus.res_data, m_data);
      chk("sh_data_in", sh_data_in, m_sh.d);
      chk("sh_dir",     sh_left_right_sel, m_sh.dir);
      chk("sh_shamt",   sh_bit_shift, m_sh.s);
`ifdef SHIFT_SEQ_LOSS_EN
      chk("res_loss",   bus.res_loss, m_loss);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [DW-1:0] d, input logic dir, input logic [SW-1:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_dir   = dir;
    bus.cmd_shamt = s;
  endtask

  task automatic chk_loss_lit(input string nm, input logic exp);
`ifdef SHIFT_SEQ_LOSS_EN
    chk(nm, bus.res_loss, exp);
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    // Reset held two clocks while a command is offered.
    rst_n = 1'b0;
    drive_cmd(8'hA5, 1'b1, 3'd2);
    bus.res_ready = 1'b1;
    step();
    step();
    chk("rst_res_valid",  bus.res_valid, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_sh_data_in", sh_data_in, 8'h00);
    chk("rst_sh_dir",     sh_left_right_sel, 1'b0);
    chk("rst_sh_shamt",   sh_bit_shift, 3'd0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single command, no shift.
    drive_cmd(8'hF0, 1'b0, 3'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("single_count", fifo_count, 3'd1);
    step();
    chk("single_valid_e1", bus.res_valid, 1'b0);
    step();
    chk("single_valid_e2", bus.res_valid, 1'b1);
    chk("single_data", bus.res_data, 8'hF0);
    chk_loss_lit("single_loss", 1'b0);
    step();

    // Back-to-back commands.
    drive_cmd(8'hF0, 1'b0, 3'd4);
    step();
    drive_cmd(8'hF0, 1'b1, 3'd1);
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("b2b_valid_a", bus.res_valid, 1'b1);
    chk("b2b_data_a", bus.res_data, 8'h00);
    chk_loss_lit("b2b_loss_a", 1'b1);
    step();
    chk("b2b_gap", bus.res_valid, 1'b0);
    step();
    chk("b2b_valid_b", bus.res_valid, 1'b1);
    chk("b2b_data_b", bus.res_data, 8'h78);
    chk_loss_lit("b2b_loss_b", 1'b0);
    step();
    step();

    // Backpressure until full: six offers, five accepted.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'h11;
      d = d * 8'(i + 1);
      drive_cmd(d, i[0], 3'(i));
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("full_count", fifo_count, 3'd4);
    chk("full_ready", bus.cmd_ready, 1'b0);
    chk("full_hold_data", bus.res_data, 8'h11);
    step();
    step();
    chk("full_stable_data", bus.res_data, 8'h11);
    chk("full_stable_valid", bus.res_valid, 1'b1);

    // Handshake and push in the same cycle while full: pop only.
    bus.res_ready = 1'b1;
    drive_cmd(8'hEE, 1'b0, 3'd1);
    step();
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    chk("simul_count", fifo_count, 3'd3);
    chk("simul_ready", bus.cmd_ready, 1'b1);
    step();
    bus.res_ready = 1'b1;
    repeat (12) step();
    chk("drain_count", fifo_count, 3'd0);
    chk("drain_valid", bus.res_valid, 1'b0);
    chk("drain_last", bus.res_data, 8'h50);

    // Reset during HOLD with three commands queued.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(8'(8'h81 + i), 1'b1, 3'(i + 1));
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("midrst_pre_count", fifo_count, 3'd3);
    chk("midrst_pre_valid", bus.res_valid, 1'b1);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", bus.res_valid, 1'b0);
    chk("midrst_count", fifo_count, 3'd0);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (6) step();
    chk("midrst_quiet", bus.res_valid, 1'b0);

    // Randomized traffic with varying consumer pressure and rare resets.
    for (int blk = 0; blk < 15; blk++) begin
      int vpct, rpct;
      vpct = $urandom_range(10, 95);
      rpct = $urandom_range(5, 100);
      for (int c = 0; c < 200; c++) begin
        bus.cmd_valid = ($urandom_range(0, 99) < vpct);
        bus.cmd_data  = 8'($urandom);
        bus.cmd_dir   = 1'($urandom);
        bus.cmd_shamt = 3'($urandom);
        bus.res_ready = ($urandom_range(0, 99) < rpct);
        rst_n         = ($urandom_range(0, 399) != 0);
        step();
      end
    end
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (12) step();
    chk("final_count", fifo_count, 3'd0);
    chk("final_valid", bus.res_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
